// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: read-side controller for the FFT sample FIFO.
// Waits for enough samples, drains FRAME_LEN words per frame, and hides the
// FIFO's 1-cycle read latency behind a 2-entry buffer feeding a valid/ready
// stream with first/last markers.
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 31,
    parameter int FRAME_LEN  = 256,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic                  fifo_almost_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           stall_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

    typedef struct packed {
        logic                  first;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [1:0]           state;
    logic [IDX_WIDTH-1:0] idx;
    logic                 inflight;
    logic                 inf_first;
    logic                 inf_last;
    entry_t               slot [2];
    logic                 head;
    logic                 tail;
    logic [1:0]           occ;

    logic       pop;
    logic [2:0] proj;
    logic       credit;
    logic       issue;
    logic       start;
    logic       drain_done;

    // Credit looks at the occupancy projected past this edge, including the
    // word already in flight, so the buffer can never take a third entry.
    always_comb begin
        pop        = m_valid & m_ready;
        proj       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        credit     = (proj <= 3'd1);
        issue      = (state == ST_RUN) && !fifo_rd_empty && credit;
        start      = (state == ST_IDLE) && enable && !fifo_almost_empty;
        drain_done = (state == ST_DRAIN) && (occ == 2'd0) && !inflight;
        tail       = head ^ occ[0];
    end

    assign fifo_rd_en = issue;
    assign frame_done = drain_done;
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign m_valid    = (occ != 2'd0);
    assign m_data     = slot[head].data;
    assign m_first    = m_valid & slot[head].first;
    assign m_last     = m_valid & slot[head].last;

    // Frame sequencing: IDLE -> RUN (issue reads) -> DRAIN (empty the buffer).
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_RUN;
                ST_RUN:   if (issue && idx == LAST_IDX) state <= ST_DRAIN;
                ST_DRAIN: if (drain_done) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Word index of the next read; first/last flags ride along with the read.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            idx       <= '0;
            inflight  <= 1'b0;
            inf_first <= 1'b0;
            inf_last  <= 1'b0;
        end else begin
            if (start)      idx <= '0;
            else if (issue) idx <= idx + 1'b1;
            inflight  <= issue;
            inf_first <= issue && (idx == '0);
            inf_last  <= issue && (idx == LAST_IDX);
        end
    end

    // 2-entry circular buffer; the returning read lands at the tail.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < 2; i++) slot[i] <= '0;
            head <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (inflight) slot[tail] <= '{first: inf_first, last: inf_last, data: fifo_rd_data};
            if (pop) head <= ~head;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Completed-frame counter (wraps) and empty-FIFO stall counter (saturates).
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (drain_done) frame_cnt <= frame_cnt + 16'd1;
            if ((state == ST_RUN) && fifo_rd_empty && credit && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with FRAME_LEN=8 and a behavioural
// 1-cycle-latency FIFO model on the read side.
module tb_fifo_frame_reader;

    localparam int DW = 31;
    localparam int FL = 8;

    logic          rd_clk;
    logic          rd_rst;
    logic          enable;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic          fifo_almost_empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_first;
    logic          m_last;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [15:0]   stall_cnt;

    fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .IDX_WIDTH(16)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_first(m_first), .m_last(m_last), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // FIFO model: written by the stimulus, read on rd_en with 1-cycle latency.
    logic [DW-1:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_rd_empty     = (wr_ptr == rd_ptr);
    assign fifo_almost_empty = ((wr_ptr - rd_ptr) < 5);

    initial fifo_rd_data = '0;
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Stream monitor: records every accepted word and watches invariants.
    logic [DW-1:0] cap_d [$];
    logic          cap_f [$];
    logic          cap_l [$];
    int done_seen = 0;
    int bad_rd    = 0;
    int bad_occ   = 0;
    int bad_hold  = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_f = 1'b0;
    logic          hold_l = 1'b0;

    always @(negedge rd_clk) begin
        if (m_valid && m_ready) begin
            cap_d.push_back(m_data);
            cap_f.push_back(m_first);
            cap_l.push_back(m_last);
        end
        if (frame_done) done_seen <= done_seen + 1;
        if (fifo_rd_en && fifo_rd_empty) bad_rd <= bad_rd + 1;
        if (dut.occ > 2'd2) bad_occ <= bad_occ + 1;
        if (hold_v && (!m_valid || m_data !== hold_d || m_first !== hold_f || m_last !== hold_l))
            bad_hold <= bad_hold + 1;
        hold_v <= !rd_rst && m_valid && !m_ready;
        hold_d <= m_data;
        hold_f <= m_first;
        hold_l <= m_last;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge rd_clk);
    endtask

    task automatic push(input int v);
        mem[wr_ptr % 256] = DW'(v);
        wr_ptr++;
    endtask

    task automatic wait_done(input string tag, input int target, input int limit);
        int n = 0;
        while (done_seen < target && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_seen >= target), 32'd1);
    endtask

    task automatic wait_cap(input string tag, input int target, input int limit);
        int n = 0;
        while (cap_d.size() < target && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(cap_d.size() >= target), 32'd1);
    endtask

    task automatic chk_frame(input string tag, input int base, input int v0);
        chk({tag, "_count"}, 32'(cap_d.size() >= base + FL), 32'd1);
        if (cap_d.size() >= base + FL) begin
            for (int k = 0; k < FL; k++) begin
                chk({tag, "_data"},  32'(cap_d[base+k]), 32'(v0 + k));
                chk({tag, "_first"}, 32'(cap_f[base+k]), 32'(k == 0));
                chk({tag, "_last"},  32'(cap_l[base+k]), 32'(k == FL - 1));
            end
        end
    endtask

    initial begin
        int base;
        int d0;
        int n;
        rd_rst  = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        smp();
        chk("rst_rd_en",      32'(fifo_rd_en), 32'd0);
        chk("rst_valid",      32'(m_valid),    32'd0);
        chk("rst_data",       32'(m_data),     32'd0);
        chk("rst_first_last", 32'({m_first, m_last}), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(frame_done), 32'd0);
        chk("rst_frame_cnt",  32'(frame_cnt),  32'd0);
        chk("rst_stall_cnt",  32'(stall_cnt),  32'd0);

        // Basic frame: preload 0..19, start and check exact cycle timing
        tick();
        rd_rst  = 1'b0;
        m_ready = 1'b1;
        for (int v = 0; v < 20; v++) push(v);
        tick();
        enable = 1'b1;
        smp();
        chk("idle_before_start", 32'(busy), 32'd0);
        for (int c = 1; c <= 27; c++) begin
            tick();
            smp();
            if (c == 1) begin
                chk("start_busy",  32'(busy),       32'd1);
                chk("start_rd_en", 32'(fifo_rd_en), 32'd1);
            end
            if (c == 2) chk("latency_no_valid", 32'(m_valid), 32'd0);
            if (c >= 3 && c <= 10) begin
                chk("f1_valid", 32'(m_valid), 32'd1);
                chk("f1_data",  32'(m_data),  32'(c - 3));
                chk("f1_first", 32'(m_first), 32'(c == 3));
                chk("f1_last",  32'(m_last),  32'(c == 10));
                chk("f1_no_done", 32'(frame_done), 32'd0);
            end
            if (c == 11) begin
                chk("f1_done",      32'(frame_done), 32'd1);
                chk("f1_drain_val", 32'(m_valid),    32'd0);
            end
            if (c == 12) begin
                chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
                chk("gap_idle",     32'(busy),      32'd0);
            end
            if (c == 13) chk("f2_busy", 32'(busy), 32'd1);
            if (c >= 15 && c <= 22) begin
                chk("f2_data",  32'(m_data),  32'(c - 7));
                chk("f2_first", 32'(m_first), 32'(c == 15));
                chk("f2_last",  32'(m_last),  32'(c == 22));
            end
            if (c == 23) chk("f2_done", 32'(frame_done), 32'd1);
            if (c >= 24) begin
                chk("gate_busy",  32'(busy),       32'd0);
                chk("gate_rd_en", 32'(fifo_rd_en), 32'd0);
                chk("gate_frame_cnt", 32'(frame_cnt), 32'd2);
            end
        end

        // Start gating release: 5th word, then underrun with 10 empty cycles
        tick();
        push(20);
        smp();
        chk("gate_still_idle", 32'(busy), 32'd0);
        tick();
        smp();
        chk("gate_started", 32'(busy), 32'd1);
        for (int c = 2; c <= 15; c++) begin
            tick();
            if (c == 10) begin
                smp();
                chk("underrun_no_rd", 32'(fifo_rd_en), 32'd0);
            end
        end
        tick();
        push(21); push(22); push(23);
        tick();
        smp();
        chk("underrun_stall_cnt", 32'(stall_cnt), 32'd10);
        wait_done("underrun_done_timeout", 3, 100);
        chk_frame("underrun", 16, 16);
        chk("underrun_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("rd_while_empty", 32'(bad_rd), 32'd0);

        // Backpressure: random m_ready over 4 frames of 0..31
        base = cap_d.size();
        for (int v = 0; v < 32; v++) push(v);
        n = 0;
        while (done_seen < 7 && n < 2000) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("bp_done_timeout", 32'(done_seen >= 7), 32'd1);
        m_ready = 1'b1;
        for (int f = 0; f < 4; f++) chk_frame("bp", base + 8 * f, 8 * f);
        chk("bp_word_count", 32'(cap_d.size()), 32'(base + 32));
        chk("bp_occ_le_2",   32'(bad_occ),  32'd0);
        chk("bp_hold",       32'(bad_hold), 32'd0);
        chk("bp_frame_cnt",  32'(frame_cnt), 32'd7);

        // Enable dropped mid-frame: frame still completes, then stays idle
        tick();
        base = cap_d.size();
        for (int v = 0; v < 8; v++) push(v);
        wait_cap("en_cap_timeout", base + 3, 100);
        enable = 1'b0;
        wait_done("en_done_timeout", 8, 100);
        chk_frame("en_drop", base, 0);
        chk("en_frame_cnt", 32'(frame_cnt), 32'd8);
        for (int v = 60; v < 68; v++) push(v);
        repeat (6) begin
            tick();
            smp();
            chk("en_stays_idle", 32'(busy), 32'd0);
        end
        chk("en_no_extra", 32'(cap_d.size()), 32'(base + 8));

        // Reset mid-frame: everything clears, no frame_done, clean restart
        d0 = done_seen;
        tick();
        enable = 1'b1;
        wait_cap("rst_cap_timeout", base + 12, 100);
        rd_rst = 1'b1;
        #1;
        chk("mrst_valid",     32'(m_valid),    32'd0);
        chk("mrst_rd_en",     32'(fifo_rd_en), 32'd0);
        chk("mrst_busy",      32'(busy),       32'd0);
        chk("mrst_flags",     32'({m_first, m_last}), 32'd0);
        chk("mrst_data",      32'(m_data),     32'd0);
        chk("mrst_frame_cnt", 32'(frame_cnt),  32'd0);
        chk("mrst_stall_cnt", 32'(stall_cnt),  32'd0);
        chk("mrst_done",      32'(frame_done), 32'd0);
        tick();
        tick();
        chk("mrst_no_done_seen", 32'(done_seen), 32'(d0));
        wr_ptr = rd_ptr;
        for (int v = 40; v < 48; v++) push(v);
        base = cap_d.size();
        rd_rst = 1'b0;
        wait_done("mrst_done_timeout", d0 + 1, 100);
        chk_frame("mrst_new", base, 40);
        chk("mrst_new_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("final_rd_while_empty", 32'(bad_rd), 32'd0);
        chk("final_occ_le_2", 32'(bad_occ), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Read-side controller for the 31-bit asynchronous sample FIFO that feeds the FFT path. It waits until the FIFO holds enough samples, then drains exactly FRAME_LEN words per frame. It hides the FIFO's 1-cycle read latency (no output register) behind a 2-entry output buffer, and presents the words on a valid/ready stream with first/last markers. It lives entirely in the FIFO read clock domain, between the FIFO read port and the FFT input.

## Interface
Parameters:
- DATA_WIDTH, 31, FIFO/stream word width.
- FRAME_LEN, 256, words per frame (2..65535).
- IDX_WIDTH, 16, width of the word-index counter; must hold FRAME_LEN-1.

Ports:
- rd_clk  in  1  FIFO read clock; all logic on its rising edge.
- rd_rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits a new frame to start; sampled only in IDLE.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_almost_empty  in  1  FIFO almost-empty (fewer than 5 words).
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_first  out  1  qualifies word index 0 of a frame.
- m_last  out  1  qualifies word index FRAME_LEN-1.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse when a frame has fully left the block.
- frame_cnt  out  16  completed frames; wraps at 2^16.
- stall_cnt  out  16  RUN cycles lost to an empty FIFO; saturates at 0xFFFF.

## Operation
- States:
  - IDLE: go to RUN when enable=1 and fifo_almost_empty=0.
  - RUN: issue FIFO reads. On issuing index FRAME_LEN-1, go to DRAIN.
  - DRAIN: no reads. Go to IDLE when the buffer is empty and no read is in flight.
- frame_done pulses on the DRAIN->IDLE transition. frame_cnt increments in the same cycle.
- In-flight flag: equals fifo_rd_en of the previous cycle. When set, fifo_rd_data is written into the buffer tail together with the index-derived first/last flags captured at issue.
- Pop: m_valid and m_ready both high.
- Issue rule: fifo_rd_en = (state==RUN) and !fifo_rd_empty and (occ + inflight - pop <= 1).
  - This is combinational on m_ready, which gives 1 word/cycle sustained throughput.
  - fifo_rd_en is never high while fifo_rd_empty=1.
- Word index: increments per issued read and resets to 0 on entering RUN.
  - m_first = head index 0; m_last = head index FRAME_LEN-1.
- m_valid = (occ != 0). m_data, m_first and m_last come from the buffer head and are stable while m_valid=1 and m_ready=0.
- stall_cnt increments in any RUN cycle where fifo_rd_empty=1 and credit exists (occ + inflight - pop <= 1).
- enable deasserted mid-frame has no effect; the frame always completes.
- Buffer overflow is impossible by construction. Verification asserts occ <= 2 at all times.

## Timing
- Reset values: state IDLE, index 0, occ 0, inflight 0. All outputs 0, including frame_cnt and stall_cnt.
- rd_rst asserted mid-frame: the partial frame is discarded, outputs clear immediately, and no frame_done is produced.
- Start latency:
  - Start condition seen at edge T: RUN from T+1, first fifo_rd_en during cycle T+1 (FIFO non-empty).
  - Word captured at edge T+2: m_valid=1, m_first=1 during cycle T+2.
- Throughput: with m_ready=1 and a non-empty FIFO, one word per cycle. A frame occupies FRAME_LEN+3 cycles from the IDLE exit through the frame_done pulse.
- Back-to-back frames: after frame_done, at least one IDLE cycle before the next RUN.
- Backpressure: m_ready=0 with a full buffer drops fifo_rd_en in the same cycle. At most one read is in flight when the buffer fills.

## Test plan
- Basic frame:
  - Stimulus: FRAME_LEN=8, FIFO preloaded with 0..19, enable=1, m_ready=1.
  - Response: stream 0..7 on 8 consecutive cycles, m_first on 0, m_last on 7, one frame_done, frame_cnt=1. The second frame 8..15 starts after one IDLE cycle.
- Start gating:
  - Stimulus: FIFO holds 4 words, enable=1.
  - Response: stays IDLE, busy=0, no fifo_rd_en. Writing a 5th word starts RUN within 2 cycles.
- Underrun mid-frame:
  - Stimulus: FRAME_LEN=8, 5 words available, then 3 more written 10 cycles later.
  - Response: fifo_rd_en never high while empty, stall_cnt=10 (±1 for the CDC flag), m_last still on the 8th word.
- Backpressure:
  - Stimulus: random m_ready (50%) over 4 frames of 8.
  - Response: data order 0..31 intact, no word duplicated or dropped, occ never exceeds 2, m_data stable while stalled.
- Reset mid-frame:
  - Stimulus: assert rd_rst after word 3 of a frame.
  - Response: all outputs 0 within the reset cycle, frame_cnt=0, no frame_done. After release with enable=1, a new frame begins with m_first.
- Enable drop:
  - Stimulus: enable deasserted after word 2.
  - Response: frame completes all 8 words, frame_done pulses, then stays IDLE.
